soc_ram_arbiter: RTL and testbench
==================================

Name: soc_ram_arbiter

Overview:
- Shares the single-port data RAM (memory_ram) between two bus masters:
  - M0: the riscv_32i_ia data port.
  - M1: a UART loader/debug DMA.
- Round-robin arbitration, an optional bus lock, and registered slave-side outputs.
- Tags each read in flight so that returning RAM data goes only to the master that issued the read.
- Sits between the masters and the RAM inside socriscv32.

Parameters:
- ADDR_W, 32, address width for both masters and the RAM.
- READ_LAT, 1, cycles from oRAM_CE&oRAM_RD until iRAM_DATA is valid. Legal range 1..4.
- LOCK_MAX, 16, maximum idle cycles a locked owner may hold the bus before the lock is force-released.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-low
- iM0_REQ  in  1  M0 access request
- iM0_WE  in  1  1=write, 0=read
- iM0_LOCK  in  1  keep ownership after this access
- iM0_ADDR  in  ADDR_W  M0 address
- iM0_WDATA  in  32  M0 write data
- oM0_GNT  out  1  request accepted this cycle (combinational)
- oM0_RVALID  out  1  read data valid for M0
- oM0_RDATA  out  32  read data for M0
- iM1_REQ, iM1_WE, iM1_LOCK, iM1_ADDR, iM1_WDATA, oM1_GNT, oM1_RVALID, oM1_RDATA: same widths and meanings as the M0 ports, for M1.
- oRAM_CE  out  1  RAM chip enable
- oRAM_RD  out  1  RAM read enable
- oRAM_WR  out  1  RAM write enable
- oRAM_ADDR  out  ADDR_W  RAM address
- oRAM_DATA  out  32  RAM write data
- iRAM_DATA  in  32  RAM read data
- oLOCK_TIMEOUT  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset (iRST=0, async):
  - All outputs are 0.
  - Last-grant pointer = M1, so M0 wins the first tie.
  - Lock cleared; idle counter = 0; read tag pipe flushed.
  - Reads in flight when reset asserts never produce RVALID.
- Transfer:
  - A transfer occurs in cycle t when iMx_REQ & oMx_GNT are both 1.
  - At most one GNT is asserted per cycle.
  - A master must hold REQ/WE/ADDR/WDATA/LOCK stable until GNT.
- Arbitration (combinational, from current REQs and registered state):
  - Lock held by x: only x may be granted; the other GNT=0.
  - No lock, one requester: that requester is granted.
  - No lock, both requesting: grant the master not granted last. The pointer updates on every transfer.
- Slave side, registered:
  - At t+1: oRAM_CE=1, oRAM_RD=~WE, oRAM_WR=WE, and ADDR/DATA from the winning master.
  - If no transfer at t, CE/RD/WR=0 at t+1.
  - ADDR/DATA hold their last value when idle.
- Throughput: back-to-back transfers, one per cycle, from either master or alternating between masters.
- Read return:
  - A tag (valid, master id) enters a READ_LAT+1 deep shift pipe on each read transfer.
  - oMx_RVALID=1 in cycle t+1+READ_LAT when the tag at the pipe output is valid and matches x.
  - oMx_RDATA=iRAM_DATA when valid, else 0.
  - Total read latency is 2 cycles at default. Writes produce no response.
  - Returns arrive in issue order, and are never lost when requests from the other master interleave.
- Lock:
  - A transfer with LOCK=1 sets (or keeps) the owner = x.
  - A transfer from the owner with LOCK=0 clears the lock at the end of that cycle.
  - While locked:
    - The idle counter increments on each cycle with no owner transfer.
    - It resets to 0 on each owner transfer.
    - When it reaches LOCK_MAX, the lock clears the next cycle and oLOCK_TIMEOUT pulses once.
  - Timeout and an owner transfer in the same cycle: the transfer wins, and the counter resets with no timeout.
- Simultaneous events: the lock is set by x in the same cycle the other master requests. The other master stays blocked from t+1 onward.
- No error response and no address decode; all addresses go to the RAM.

Decomposition:
- Shared include soc_bus_defs.vh:
  - Master id constants MID_CORE=0, MID_LDR=1.
  - Access-type constants.
  - Default READ_LAT/LOCK_MAX.
- Sub-module rd_tag_pipe:
  - Parameterised READ_LAT+1 shift register of {valid, id}, with async clear.
  - Reused later for UART register reads.
- Arbitration, lock FSM (UNLOCKED/LOCKED_M0/LOCKED_M1) and slave registers stay in the top module.

Test Plan:
- Reset, then M0 read at 0x10 alone:
  - GNT0 in cycle 1.
  - oRAM_CE=1, oRAM_RD=1, oRAM_ADDR=0x10 in cycle 2.
  - RAM returns 0xDEADBEEF; oM0_RVALID=1 with that data in cycle 3. oM1_RVALID stays 0.
- Both masters issue reads continuously for 6 cycles:
  - Grants alternate M0,M1,M0,M1,M0,M1.
  - Each RVALID goes to the correct master, 2 cycles after its grant, with no drops.
- M1 write 0x20 = 0x12345678:
  - oRAM_WR=1, oRAM_DATA=0x12345678 one cycle after GNT1.
  - No RVALID on either master.
- M1 locks (LOCK=1), M0 requests continuously, M1 does 3 more locked accesses then a LOCK=0 access:
  - GNT0 stays 0 throughout the locked sequence.
  - GNT0 asserts the cycle after M1's unlock transfer.
- M0 locks, then idles while M1 requests, LOCK_MAX=4:
  - oLOCK_TIMEOUT pulses once after 4 idle cycles.
  - GNT1 is asserted the following cycle.
- M0 read granted, then iRST=0 asserted one cycle later for 2 cycles:
  - All outputs 0 during reset.
  - No RVALID after release.
  - First post-reset tie goes to M0.

Source files
------------

// File: rtl/soc_ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: master ids, access types,
// default timing parameters, lock FSM states and the read-tag record.
package soc_ram_arbiter_pkg;

   localparam logic MID_CORE = 1'b0;
   localparam logic MID_LDR  = 1'b1;

   localparam int DEF_READ_LAT = 1;
   localparam int DEF_LOCK_MAX = 16;

   typedef enum logic {
      ACC_READ  = 1'b0,
      ACC_WRITE = 1'b1
   } acc_t;

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCKED_M0,
      LOCKED_M1
   } lock_state_t;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   function automatic lock_state_t lock_of(input logic id);
      return (id == MID_LDR) ? LOCKED_M1 : LOCKED_M0;
   endfunction

endpackage

// File: rtl/soc_ram_arbiter_rd_tag_pipe.sv
// Fixed-depth shift pipe of {valid, id} tags that tracks reads in flight so
// returning data can be steered to the issuing master.
module rd_tag_pipe
   import soc_ram_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t [DEPTH-1:0] stage_reg;

   // Clearing every stage on reset discards reads that were already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_reg <= '0;
      end else begin
         stage_reg[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/soc_ram_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM, with bus lock,
// lock timeout, registered RAM-side outputs and tagged read return.
module soc_ram_arbiter
   import soc_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = DEF_READ_LAT,
   parameter int LOCK_MAX = DEF_LOCK_MAX
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iM0_REQ,
   input  logic              iM0_WE,
   input  logic              iM0_LOCK,
   input  logic [ADDR_W-1:0] iM0_ADDR,
   input  logic [31:0]       iM0_WDATA,
   output logic              oM0_GNT,
   output logic              oM0_RVALID,
   output logic [31:0]       oM0_RDATA,
   input  logic              iM1_REQ,
   input  logic              iM1_WE,
   input  logic              iM1_LOCK,
   input  logic [ADDR_W-1:0] iM1_ADDR,
   input  logic [31:0]       iM1_WDATA,
   output logic              oM1_GNT,
   output logic              oM1_RVALID,
   output logic [31:0]       oM1_RDATA,
   output logic              oRAM_CE,
   output logic              oRAM_RD,
   output logic              oRAM_WR,
   output logic [ADDR_W-1:0] oRAM_ADDR,
   output logic [31:0]       oRAM_DATA,
   input  logic [31:0]       iRAM_DATA,
   output logic              oLOCK_TIMEOUT
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   lock_state_t       lock_state_reg;
   logic              last_gnt_reg;
   logic [CNT_W-1:0]  idle_cnt_reg;
   logic              ram_ce_reg;
   logic              ram_rd_reg;
   logic              ram_wr_reg;
   logic [ADDR_W-1:0] ram_addr_reg;
   logic [31:0]       ram_data_reg;

   logic              gnt0;
   logic              gnt1;
   logic              xfer;
   logic              xfer_id;
   logic              xfer_we;
   logic              xfer_lock;
   logic [ADDR_W-1:0] xfer_addr;
   logic [31:0]       xfer_wdata;
   logic              locked;
   logic              timeout;
   rd_tag_t           tag_in;
   rd_tag_t           tag_out;

   // Grants are forced low while reset is asserted so every output reads 0.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (iRST) begin
         case (lock_state_reg)
            LOCKED_M0: gnt0 = iM0_REQ;
            LOCKED_M1: gnt1 = iM1_REQ;
            default: begin
               if (iM0_REQ && iM1_REQ) begin
                  gnt0 = (last_gnt_reg == MID_LDR);
                  gnt1 = (last_gnt_reg == MID_CORE);
               end else begin
                  gnt0 = iM0_REQ;
                  gnt1 = iM1_REQ;
               end
            end
         endcase
      end
   end

   assign xfer       = gnt0 | gnt1;
   assign xfer_id    = gnt1 ? MID_LDR : MID_CORE;
   assign xfer_we    = gnt1 ? iM1_WE    : iM0_WE;
   assign xfer_lock  = gnt1 ? iM1_LOCK  : iM0_LOCK;
   assign xfer_addr  = gnt1 ? iM1_ADDR  : iM0_ADDR;
   assign xfer_wdata = gnt1 ? iM1_WDATA : iM0_WDATA;

   // While locked only the owner can be granted, so any transfer is an owner transfer.
   assign locked  = (lock_state_reg != UNLOCKED);
   assign timeout = locked && !xfer && (idle_cnt_reg == CNT_MAX);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         lock_state_reg <= UNLOCKED;
         last_gnt_reg   <= MID_LDR;
         idle_cnt_reg   <= '0;
         ram_ce_reg     <= 1'b0;
         ram_rd_reg     <= 1'b0;
         ram_wr_reg     <= 1'b0;
         ram_addr_reg   <= '0;
         ram_data_reg   <= '0;
      end else begin
         ram_ce_reg <= xfer;
         ram_rd_reg <= xfer && (xfer_we == ACC_READ);
         ram_wr_reg <= xfer && (xfer_we == ACC_WRITE);
         if (xfer) begin
            last_gnt_reg <= xfer_id;
            ram_addr_reg <= xfer_addr;
            ram_data_reg <= xfer_wdata;
         end

         case (lock_state_reg)
            UNLOCKED: begin
               idle_cnt_reg <= '0;
               if (xfer && xfer_lock) begin
                  lock_state_reg <= lock_of(xfer_id);
               end
            end
            default: begin
               if (xfer) begin
                  idle_cnt_reg <= '0;
                  if (!xfer_lock) begin
                     lock_state_reg <= UNLOCKED;
                  end
               end else if (timeout) begin
                  idle_cnt_reg   <= '0;
                  lock_state_reg <= UNLOCKED;
               end else begin
                  idle_cnt_reg <= idle_cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

   assign tag_in.valid = xfer && (xfer_we == ACC_READ);
   assign tag_in.id    = xfer_id;

   // One stage for the slave-side register plus READ_LAT stages for the RAM.
   rd_tag_pipe #(
      .DEPTH (READ_LAT + 1)
   ) u_rd_tag_pipe (
      .clk     (iCLK),
      .rst_n   (iRST),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign oM0_GNT       = gnt0;
   assign oM1_GNT       = gnt1;
   assign oM0_RVALID    = tag_out.valid && (tag_out.id == MID_CORE);
   assign oM1_RVALID    = tag_out.valid && (tag_out.id == MID_LDR);
   assign oM0_RDATA     = oM0_RVALID ? iRAM_DATA : '0;
   assign oM1_RDATA     = oM1_RVALID ? iRAM_DATA : '0;
   assign oRAM_CE       = ram_ce_reg;
   assign oRAM_RD       = ram_rd_reg;
   assign oRAM_WR       = ram_wr_reg;
   assign oRAM_ADDR     = ram_addr_reg;
   assign oRAM_DATA     = ram_data_reg;
   assign oLOCK_TIMEOUT = timeout;

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Directed bench for soc_ram_arbiter: arbitration, read return steering,
// writes, bus lock, lock timeout and reset while a read is in flight.
module tb_soc_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic        ram_ce, ram_rd, ram_wr;
   logic [31:0] ram_addr, ram_wdata, ram_q;
   logic        lock_timeout;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   soc_ram_arbiter #(
      .ADDR_W   (32),
      .READ_LAT (1),
      .LOCK_MAX (4)
   ) dut (
      .iCLK          (clk),
      .iRST          (rst_n),
      .iM0_REQ       (m0_req),
      .iM0_WE        (m0_we),
      .iM0_LOCK      (m0_lock),
      .iM0_ADDR      (m0_addr),
      .iM0_WDATA     (m0_wdata),
      .oM0_GNT       (gnt0),
      .oM0_RVALID    (rvalid0),
      .oM0_RDATA     (rdata0),
      .iM1_REQ       (m1_req),
      .iM1_WE        (m1_we),
      .iM1_LOCK      (m1_lock),
      .iM1_ADDR      (m1_addr),
      .iM1_WDATA     (m1_wdata),
      .oM1_GNT       (gnt1),
      .oM1_RVALID    (rvalid1),
      .oM1_RDATA     (rdata1),
      .oRAM_CE       (ram_ce),
      .oRAM_RD       (ram_rd),
      .oRAM_WR       (ram_wr),
      .oRAM_ADDR     (ram_addr),
      .oRAM_DATA     (ram_wdata),
      .iRAM_DATA     (ram_q),
      .oLOCK_TIMEOUT (lock_timeout)
   );

   // One-cycle-latency RAM stub with a fixed content pattern.
   always @(posedge clk) begin
      if (ram_ce && ram_rd) begin
         ram_q <= (ram_addr == 32'h10) ? 32'hDEADBEEF : (32'hA500_0000 | ram_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1 ("rst_ce", ram_ce, 1'b0);
      chk1 ("rst_rd", ram_rd, 1'b0);
      chk1 ("rst_wr", ram_wr, 1'b0);
      chk32("rst_addr", ram_addr, 32'h0);
      chk32("rst_wdata", ram_wdata, 32'h0);
      chk1 ("rst_gnt0", gnt0, 1'b0);
      chk1 ("rst_gnt1", gnt1, 1'b0);
      chk1 ("rst_rvalid0", rvalid0, 1'b0);
      chk1 ("rst_rvalid1", rvalid1, 1'b0);
      chk1 ("rst_timeout", lock_timeout, 1'b0);
      tick();
      rst_n = 1'b1;

      // Lone M0 read at 0x10
      tick();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      chk1("rd0_gnt0", gnt0, 1'b1);
      chk1("rd0_gnt1", gnt1, 1'b0);
      tick();
      m0_req = 0;
      @(negedge clk);
      chk1 ("rd0_ce", ram_ce, 1'b1);
      chk1 ("rd0_rd", ram_rd, 1'b1);
      chk1 ("rd0_wr", ram_wr, 1'b0);
      chk32("rd0_addr", ram_addr, 32'h10);
      tick();
      @(negedge clk);
      chk1 ("rd0_rvalid0", rvalid0, 1'b1);
      chk32("rd0_rdata0", rdata0, 32'hDEADBEEF);
      chk1 ("rd0_rvalid1", rvalid1, 1'b0);

      // M1 write 0x20 = 0x12345678
      tick();
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
      @(negedge clk);
      chk1("wr1_gnt1", gnt1, 1'b1);
      chk1("wr1_gnt0", gnt0, 1'b0);
      tick();
      m1_req = 0;
      @(negedge clk);
      chk1 ("wr1_ce", ram_ce, 1'b1);
      chk1 ("wr1_wr", ram_wr, 1'b1);
      chk1 ("wr1_rd", ram_rd, 1'b0);
      chk32("wr1_addr", ram_addr, 32'h20);
      chk32("wr1_data", ram_wdata, 32'h12345678);
      tick();
      @(negedge clk);
      chk1("wr1_no_rvalid0", rvalid0, 1'b0);
      chk1("wr1_no_rvalid1", rvalid1, 1'b0);

      // Both masters read back-to-back; grants alternate starting with M0
      m0_we = 0; m1_we = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         m0_req  = (c < 6);
         m1_req  = (c < 6);
         m0_addr = 32'h30 + 32'((c + 1) / 2);
         m1_addr = 32'h50 + 32'(c / 2);
         @(negedge clk);
         chk1($sformatf("alt_gnt0_c%0d", c), gnt0, (c < 6) && (c % 2 == 0));
         chk1($sformatf("alt_gnt1_c%0d", c), gnt1, (c < 6) && (c % 2 == 1));
         if (c >= 2) begin
            if ((c - 2) % 2 == 0) begin
               chk1 ($sformatf("alt_rvalid0_c%0d", c), rvalid0, 1'b1);
               chk32($sformatf("alt_rdata0_c%0d", c), rdata0, 32'hA500_0030 + 32'((c - 2) / 2));
               chk1 ($sformatf("alt_norv1_c%0d", c), rvalid1, 1'b0);
            end else begin
               chk1 ($sformatf("alt_rvalid1_c%0d", c), rvalid1, 1'b1);
               chk32($sformatf("alt_rdata1_c%0d", c), rdata1, 32'hA500_0050 + 32'((c - 2) / 2));
               chk1 ($sformatf("alt_norv0_c%0d", c), rvalid0, 1'b0);
            end
         end else begin
            chk1($sformatf("alt_norv0_c%0d", c), rvalid0, 1'b0);
            chk1($sformatf("alt_norv1_c%0d", c), rvalid1, 1'b0);
         end
      end

      // M0 write so M1 wins the next tie, then M1 locks the bus
      tick();
      m0_req = 1; m0_we = 1; m0_addr = 32'h60; m0_wdata = 32'h0;
      @(negedge clk);
      chk1("pre_lock_gnt0", gnt0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         tick();
         m0_req = 1; m0_we = 1; m0_addr = 32'h61;
         m1_req = (c < 5); m1_we = 1; m1_lock = (c < 4);
         m1_addr = 32'h70 + 32'(c); m1_wdata = 32'(c);
         @(negedge clk);
         chk1($sformatf("lock_gnt0_c%0d", c), gnt0, c == 5);
         chk1($sformatf("lock_gnt1_c%0d", c), gnt1, c < 5);
      end

      // M0 locks then idles; M1 is held off until the lock times out
      tick();
      m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h80;
      m1_req = 0; m1_lock = 0;
      @(negedge clk);
      chk1("to_lock_gnt0", gnt0, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         m0_req = 0; m0_lock = 0;
         m1_req = 1; m1_we = 1; m1_addr = 32'h90;
         @(negedge clk);
         chk1($sformatf("to_pulse_k%0d", k), lock_timeout, k == 5);
         chk1($sformatf("to_gnt1_k%0d", k), gnt1, k == 6);
      end
      tick();
      m1_req = 0;

      // Reset one cycle after an M0 read is granted
      tick();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      chk1("rr_gnt0", gnt0, 1'b1);
      tick();
      m0_req = 0;
      rst_n = 1'b0;
      @(negedge clk);
      chk1 ("rr_ce", ram_ce, 1'b0);
      chk1 ("rr_rd", ram_rd, 1'b0);
      chk32("rr_addr", ram_addr, 32'h0);
      chk32("rr_wdata", ram_wdata, 32'h0);
      chk1 ("rr_rvalid0_a", rvalid0, 1'b0);
      tick();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h20;
      @(negedge clk);
      chk1 ("rr_gnt0_in_rst", gnt0, 1'b0);
      chk1 ("rr_gnt1_in_rst", gnt1, 1'b0);
      chk1 ("rr_rvalid0_b", rvalid0, 1'b0);
      chk32("rr_rdata0_b", rdata0, 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk1("rr_tie_gnt0", gnt0, 1'b1);
      chk1("rr_tie_gnt1", gnt1, 1'b0);
      chk1("rr_rvalid0_c", rvalid0, 1'b0);
      tick();
      m0_req = 0; m1_req = 0;
      @(negedge clk);
      chk1 ("rr_ce2", ram_ce, 1'b1);
      chk32("rr_addr2", ram_addr, 32'h10);
      chk1 ("rr_rvalid0_d", rvalid0, 1'b0);
      tick();
      @(negedge clk);
      chk1 ("rr_rvalid0_e", rvalid0, 1'b1);
      chk32("rr_rdata0_e", rdata0, 32'hDEADBEEF);
      chk1 ("rr_rvalid1_e", rvalid1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
